// File: rtl/switch_pkg.sv
`default_nettype none
// ============================================================================
//  Package  : switch_pkg
//  Purpose  : Shared definitions for the packet switch: scheduler state
//             encoding and the header length field position and width.
//  Revision : 1.0  initial release
// ============================================================================
package switch_pkg;

  // Output scheduler states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_BODY = 2'd2
  } state_e;

  // Header word: payload length L lives in bits [HDR_LEN_LSB +: HDR_LEN_W]
  localparam int HDR_LEN_LSB = 0;
  localparam int HDR_LEN_W   = 4;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter
//  Purpose  : Combinational rotate-priority arbiter. The search starts at
//             last_grant+1 and wraps modulo NPORT, so the previous winner has
//             the lowest priority.
//  Revision : 1.0  initial release
// ============================================================================
module rr_arbiter
  import switch_pkg::*;
#(
  parameter int NPORT = 4,
  parameter int PW    = 2
) (
  input  logic [NPORT-1:0] req,
  input  logic [PW-1:0]    last_grant,
  output logic [PW-1:0]    grant,
  output logic             any_req
);

  logic [31:0] idx;

  // Scan from the farthest candidate down to the nearest so the nearest
  // requester after last_grant is the final (winning) assignment.
  always_comb begin
    grant   = '0;
    idx     = '0;
    any_req = |req;
    for (int k = NPORT; k >= 1; k--) begin
      idx = (32'(last_grant) + 32'(k)) % 32'(NPORT);
      if (req[idx[PW-1:0]]) begin
        grant = idx[PW-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/switch_out_sched.sv
`default_nettype none
// ============================================================================
//  Module   : switch_out_sched
//  Purpose  : Output-port scheduler. Picks a non-empty input queue round-robin,
//             drains one whole packet (header + L payload words) from it and
//             forwards it as a framed (sop/eop) word stream.
//  Revision : 1.0  initial release
// ============================================================================
module switch_out_sched
  import switch_pkg::*;
#(
  parameter int NPORT = 4,
  parameter int DATA  = 8,
  parameter int LEN_W = HDR_LEN_W,
  parameter int PW    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NPORT-1:0]      q_empty,
  output logic [NPORT-1:0]      q_read_req,
  input  logic [NPORT*DATA-1:0] q_read_data,
  input  logic [NPORT-1:0]      q_read_valid,
  input  logic                  out_afull,
  output logic [DATA-1:0]       out_data,
  output logic                  out_valid,
  output logic                  out_sop,
  output logic                  out_eop,
  output logic [PW-1:0]         out_port,
  output logic                  busy,
  output logic                  proto_err
);

  // Counters hold up to 2^LEN_W without wrapping
  localparam int             CW       = LEN_W + 1;
  localparam logic [PW-1:0]  LAST_RST = PW'(NPORT - 1);

  state_e            state_q, state_d;
  logic [PW-1:0]     grant_q, grant_d;
  logic [PW-1:0]     last_grant_q, last_grant_d;
  logic [CW-1:0]     req_left_q, req_left_d;
  logic [CW-1:0]     rx_left_q, rx_left_d;
  logic [DATA-1:0]   out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              out_sop_q, out_sop_d;
  logic              out_eop_q, out_eop_d;
  logic [PW-1:0]     out_port_q, out_port_d;
  logic              proto_err_q, proto_err_d;

  logic [PW-1:0]     arb_grant;
  logic              arb_any;
  logic              issue;
  logic              accept;
  logic              stray;
  logic [NPORT-1:0]  grant_mask;
  logic [DATA-1:0]   word;
  logic [CW-1:0]     hdr_len;

  rr_arbiter #(
    .NPORT (NPORT),
    .PW    (PW)
  ) u_arb (
    .req        (~q_empty),
    .last_grant (last_grant_q),
    .grant      (arb_grant),
    .any_req    (arb_any)
  );

  // A read goes out only while words remain to request, the granted queue has
  // data and the downstream FIFO can absorb the word already in flight.
  assign issue      = (state_q != ST_IDLE) && (req_left_q != '0) &&
                      !q_empty[grant_q] && !out_afull;
  assign grant_mask = NPORT'(1) << grant_q;
  assign word       = q_read_data[grant_q*DATA +: DATA];
  assign hdr_len    = {1'b0, word[HDR_LEN_LSB +: LEN_W]};
  // rx_left is zero outside a packet, so this also rejects returns in IDLE
  assign accept     = q_read_valid[grant_q] && (rx_left_q != '0);
  assign stray      = ((q_read_valid & ~grant_mask) != '0) ||
                      (q_read_valid[grant_q] && !accept);

  // Read request decode: only the granted queue may be requested
  always_comb begin
    q_read_req          = '0;
    q_read_req[grant_q] = issue;
  end

  // Next-state, counter and output-register computation
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    req_left_d   = req_left_q;
    rx_left_d    = rx_left_q;
    out_data_d   = '0;
    out_valid_d  = 1'b0;
    out_sop_d    = 1'b0;
    out_eop_d    = 1'b0;
    out_port_d   = '0;
    proto_err_d  = proto_err_q | stray;

    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = word;
      out_port_d  = grant_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          grant_d    = arb_grant;
          req_left_d = CW'(1);
          rx_left_d  = CW'(1);
          state_d    = ST_HDR;
        end
      end
      ST_HDR: begin
        if (issue) begin
          req_left_d = req_left_q - CW'(1);
        end
        if (accept) begin
          out_sop_d = 1'b1;
          if (hdr_len == '0) begin
            out_eop_d    = 1'b1;
            rx_left_d    = '0;
            last_grant_d = grant_q;
            state_d      = ST_IDLE;
          end else begin
            req_left_d = hdr_len;
            rx_left_d  = hdr_len;
            state_d    = ST_BODY;
          end
        end
      end
      ST_BODY: begin
        if (issue) begin
          req_left_d = req_left_q - CW'(1);
        end
        if (accept) begin
          rx_left_d = rx_left_q - CW'(1);
          if (rx_left_q == CW'(1)) begin
            out_eop_d    = 1'b1;
            last_grant_d = grant_q;
            state_d      = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any packet in progress
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= LAST_RST;
      req_left_q   <= '0;
      rx_left_q    <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      out_sop_q    <= 1'b0;
      out_eop_q    <= 1'b0;
      out_port_q   <= '0;
      proto_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      req_left_q   <= req_left_d;
      rx_left_q    <= rx_left_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      out_sop_q    <= out_sop_d;
      out_eop_q    <= out_eop_d;
      out_port_q   <= out_port_d;
      proto_err_q  <= proto_err_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_sop   = out_sop_q;
  assign out_eop   = out_eop_q;
  assign out_port  = out_port_q;
  assign busy      = (state_q != ST_IDLE);
  assign proto_err = proto_err_q;

endmodule
`default_nettype wire

// File: doc/switch_out_sched.md
Name: switch_out_sched

Overview:
- Output-port scheduler for the packet switch.
- Shares one output link between NPORT input queues, each built from a single-clock FIFO (fifo_one_clk, one-cycle read latency).
- Picks a non-empty queue round-robin and drains exactly one whole packet from it: header plus the payload length the header encodes.
- Presents that packet as a framed word stream (sop/eop) to the downstream output FIFO.

Parameters:
- NPORT, 4, number of input queues (2..8).
- DATA, 8, FIFO word width.
- LEN_W, 4, header length field width; header bits [LEN_W-1:0] = payload words L (LEN_W <= DATA).
- PW, 2, port-index width, clog2(NPORT).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous active-low reset.
- q_empty  in  NPORT  per-queue fifo_empty.
- q_read_req  out  NPORT  per-queue read_req; at most one bit set.
- q_read_data  in  NPORT*DATA  per-queue read_data; queue i at [i*DATA +: DATA].
- q_read_valid  in  NPORT  per-queue read_data_valid, one cycle after read_req.
- out_afull  in  1  downstream FIFO almost-full.
- out_data  out  DATA  forwarded word.
- out_valid  out  1  out_data valid this cycle.
- out_sop  out  1  header word marker.
- out_eop  out  1  last word of packet marker.
- out_port  out  PW  source queue of current word.
- busy  out  1  state != IDLE.
- proto_err  out  1  sticky; unexpected q_read_valid.

Behaviour:
- Reset (rst==0 at a clk edge): state=IDLE, q_read_req=0, out_* = 0, busy=0, proto_err=0, last_grant=NPORT-1 (queue 0 wins first), counters 0. Reset mid-packet abandons the packet with no eop. Queue contents are the FIFO's concern.
- q_read_req is combinational: bit g is high when state in {HDR, BODY}, g==grant, req_left>0, !q_empty[g] and !out_afull. All other bits are 0.
- All out_* are registered: a word accepted on q_read_valid[grant] at edge k appears on out_* from edge k. Pipeline is read_req cycle -> data cycle -> out register, so out_valid rises 2 cycles after its read_req.
- IDLE: if any !q_empty[i], grant = first non-empty queue searching last_grant+1, +2, ... modulo NPORT. Then req_left=1, rx_left=1, go HDR. Decision takes 1 cycle; there is no read in IDLE.
- HDR: request the single header word. When the header returns: out_sop=1, L = data[LEN_W-1:0].
  - L==0: out_eop=1 in the same cycle, last_grant=grant, go IDLE.
  - L>0: req_left=L, rx_left=L, go BODY.
- BODY: each issued read decrements req_left. Each valid word decrements rx_left and is forwarded. The word that takes rx_left from 1 to 0 carries out_eop=1; then last_grant=grant, go IDLE.
- Stalls: q_empty[grant] or out_afull pause requests mid-packet. No switching of queues mid-packet, and no timeout.
- out_afull must assert while the downstream FIFO still has >=1 free slot, because one word may already be in flight.
- Back-to-back packets always get at least one idle cycle (IDLE) between a packet's eop and the next header's read_req.
- A single queue that stays non-empty is re-granted only if no other queue is non-empty (fairness).
- q_read_valid on a non-granted bit, or while rx_left==0: the word is dropped and proto_err is set sticky until reset.
- Maximum packet size is 2^LEN_W words; the counters are LEN_W+1 bits wide, with no wrap.

Decomposition:
- Shared package/include (switch_pkg): state encoding (IDLE, HDR, BODY) and the header field position/width constants (HDR_LEN_LSB, LEN_W). The same constants are used by the packet generator and the checker.
- One sub-module, rr_arbiter: inputs req[NPORT] and last_grant; outputs grant and any_req. Purely combinational rotate-priority. The FSM, counters and output register stay in switch_out_sched.

Test Plan:
- Single packet: queue 2 holds header 0x03 + payload A1 A2 A3, others empty -> out words 03(sop) A1 A2 A3(eop), out_port=2, 4 read_reqs on bit 2 only, busy falls after eop.
- Zero length: queue 0 holds header 0x00 -> one output word with sop=eop=1, then back to IDLE.
- Round-robin: all 4 queues hold one 2-payload packet each, after reset -> packets leave in order 0,1,2,3. A second set then leaves 0,1,2,3 again. No interleaving of words within any packet.
- Mid-packet stall: queue 1 holds header 0x04 plus 2 payload words, the rest written 10 cycles later -> read_req drops while empty, the packet completes intact, and no other queue is granted meanwhile.
- Backpressure: out_afull forced high for 5 cycles mid-packet -> no read_req during those cycles, at most 1 word output after the assertion edge, and no loss after release.
- Protocol error / reset: drive q_read_valid[3] while grant=0 -> proto_err=1 and stays 1. Then rst=0 mid-packet -> all outputs 0 at the next edge, and the next grant is queue 0.
